bin_to_seg_frame: RTL and testbench
===================================

Name: bin_to_seg_frame

Overview:
- Upstream feeder for the 4-cell seven-segment display stage.
- Accepts an unsigned binary value on a start pulse and converts it to BCD with a sequential double-dabble engine (one bit per clock).
- Encodes each BCD digit into an 8-bit segment pattern and presents a registered frame, seg_frame.
- seg_frame connects directly to the display stage's r_val input.

Parameters:
- NUMCELLS, 4, number of display cells/digits; frame width is 8*NUMCELLS.
- BINW, 14, width of binary input.
- LZB, 1, leading-zero blanking enable (1 = blank leading zero cells).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request conversion of bin_in; sampled only in IDLE.
- bin_in  input  BINW  unsigned value; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when seg_frame has been updated.
- seg_frame  output  8*NUMCELLS  segment patterns, most significant cell at the top byte; feeds the display r_val.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE, busy=0, done=0.
  - seg_frame = all 0x00 (blank).
  - Iteration counter and shift register cleared.
- Reset mid-conversion aborts the conversion with no done pulse; seg_frame is blanked.
- Segment byte format is {a,b,c,d,e,f,g,dp}, MSB = a; dp is always 0.
  - Digit codes 0–9: FC, 60, DA, F2, 66, B6, BE, E0, FE, F6.
  - DASH = 02; BLANK = 00.
- FSM states: IDLE, CONVERT, ENCODE.
- IDLE:
  - busy=0.
  - If start=1, on that edge:
    - load shift register {BCD=0, bin=bin_in};
    - set ovf = (bin_in > 10^NUMCELLS - 1);
    - counter=0; go to CONVERT.
- CONVERT:
  - busy=1.
  - Each edge: every 4-bit BCD nibble that is ≥5 gets +3, then the whole register shifts left 1; counter++.
  - After BINW iterations go to ENCODE.
  - BCD field width is 4*NUMCELLS; intermediate nibble overflow cannot occur when ovf=0.
  - When ovf=1 the BCD result is don't-care.
- ENCODE:
  - busy=1.
  - On the edge:
    - write seg_frame;
    - done=1 for exactly the next cycle;
    - busy=0; go to IDLE.
- Latency: with the accepting edge as edge 0, seg_frame updates and done asserts at edge BINW+1 (15 for the default). busy is high from edge 0 until edge BINW+1.
- Frame content:
  - ovf=1: every cell = DASH.
  - Otherwise cell k (bits [8k+7:8k]) encodes BCD digit k, with cell 0 the least significant.
  - LZB=1: cells above the most significant nonzero digit are BLANK; cell 0 always shows its digit, so value 0 shows "0".
- start while busy is ignored; there is no queuing.
- start in the done cycle: the FSM is already in IDLE, so the request is accepted.
- seg_frame holds its value between conversions; the downstream display stage samples it freely.
- bin_in changes after acceptance have no effect.

Decomposition:
- Package seg_pkg holds:
  - the localparams for the digit patterns ZERO..NINE, DASH and BLANK;
  - the FSM state enum.
- One sub-module, seg_digit_enc: combinational 4-bit BCD → 8-bit pattern lookup using seg_pkg constants. Non-decimal input 10–15 maps to DASH.
- It is instantiated NUMCELLS times via generate.

Test Plan:
- Hold reset_n=0 for 3 cycles with start=1 → busy=0, done=0, seg_frame=0x00000000; no conversion starts.
- bin_in=5678, start pulse → done at edge 15, busy low in the same cycle, seg_frame=0xB6BEE0FE.
- bin_in=42 with LZB=1 → seg_frame=0x000066DA. bin_in=0 → seg_frame=0x000000FC. Rerun with LZB=0 → 0xFCFC66DA and 0xFCFCFCFC.
- bin_in=10000 (overflow) → seg_frame=0x02020202 after the same latency. bin_in=9999 → 0xF6F6F6F6.
- Conversion of 1234, then start with bin_in=8888 pulsed at edges 3 and 7 (while busy) → single done, seg_frame=0x60DAF266. Start asserted in the done cycle with bin_in=8888 → second result 0xFEFEFEFE 15 edges later.
- Start 5678, drop reset_n at edge 6 for one cycle → no done pulse, seg_frame=0x00000000, state IDLE. The next start converts normally.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment frame builder: segment patterns in
// {a,b,c,d,e,f,g,dp} order and the conversion FSM state type.
package seg_pkg;

    localparam logic [7:0] ZERO  = 8'hFC;
    localparam logic [7:0] ONE   = 8'h60;
    localparam logic [7:0] TWO   = 8'hDA;
    localparam logic [7:0] THREE = 8'hF2;
    localparam logic [7:0] FOUR  = 8'h66;
    localparam logic [7:0] FIVE  = 8'hB6;
    localparam logic [7:0] SIX   = 8'hBE;
    localparam logic [7:0] SEVEN = 8'hE0;
    localparam logic [7:0] EIGHT = 8'hFE;
    localparam logic [7:0] NINE  = 8'hF6;
    localparam logic [7:0] DASH  = 8'h02;
    localparam logic [7:0] BLANK = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        ENCODE  = 2'd2
    } seg_state_t;

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seg_digit_enc.sv
// Combinational BCD digit to segment pattern lookup; non-decimal codes show a dash.
module seg_digit_enc
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = DASH;
        case (digit)
            4'd0:    pattern = ZERO;
            4'd1:    pattern = ONE;
            4'd2:    pattern = TWO;
            4'd3:    pattern = THREE;
            4'd4:    pattern = FOUR;
            4'd5:    pattern = FIVE;
            4'd6:    pattern = SIX;
            4'd7:    pattern = SEVEN;
            4'd8:    pattern = EIGHT;
            4'd9:    pattern = NINE;
            default: pattern = DASH;
        endcase
    end

endmodule

// File: rtl/bin_to_seg_frame.sv
// Binary to seven-segment frame: double-dabble BCD conversion, one bit per clock,
// then a registered frame update with a one-cycle done pulse.
module bin_to_seg_frame
    import seg_pkg::*;
#(
    parameter int NUMCELLS = 4,
    parameter int BINW     = 14,
    parameter int LZB      = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BINW-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [8*NUMCELLS-1:0] seg_frame,
    output seg_state_t            state
);

    localparam int BCDW = 4 * NUMCELLS;
    localparam int SW   = BCDW + BINW;
    localparam int CW   = $clog2(BINW + 1);
    localparam longint MAXV = pow10(NUMCELLS) - 1;

    // Handshake: start is sampled only while state is IDLE; done is a one-cycle
    // pulse coinciding with the first cycle seg_frame shows the new result.

    seg_state_t            state_next;
    logic [SW-1:0]         sreg;
    logic [SW-1:0]         adj;
    logic [SW-1:0]         shifted;
    logic [CW-1:0]         cnt;
    logic                  ovf;
    logic [7:0]            digit_pat [NUMCELLS];
    logic [8*NUMCELLS-1:0] frame_next;
    logic                  seen;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONVERT;
            CONVERT: if (cnt == CW'(BINW - 1)) state_next = ENCODE;
            ENCODE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == CONVERT) || (state == ENCODE);

    // Add-3 correction on every BCD nibble, then shift the whole register left.
    always_comb begin
        adj = sreg;
        for (int k = 0; k < NUMCELLS; k++) begin
            if (sreg[BINW+4*k +: 4] >= 4'd5) begin
                adj[BINW+4*k +: 4] = sreg[BINW+4*k +: 4] + 4'd3;
            end
        end
        shifted = {adj[SW-2:0], 1'b0};
    end

    for (genvar gi = 0; gi < NUMCELLS; gi++) begin : g_enc
        seg_digit_enc u_enc (
            .digit   (sreg[BINW+4*gi +: 4]),
            .pattern (digit_pat[gi])
        );
    end

    // Walk from the top cell down; a cell is blank until a nonzero digit has been seen.
    always_comb begin
        frame_next = '0;
        seen       = 1'b0;
        for (int k = NUMCELLS - 1; k >= 0; k--) begin
            seen = seen | (sreg[BINW+4*k +: 4] != 4'd0);
            if (ovf) begin
                frame_next[8*k +: 8] = DASH;
            end else if ((LZB != 0) && (k != 0) && !seen) begin
                frame_next[8*k +: 8] = BLANK;
            end else begin
                frame_next[8*k +: 8] = digit_pat[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sreg      <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            done      <= 1'b0;
            seg_frame <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg <= {{BCDW{1'b0}}, bin_in};
                        ovf  <= (64'(bin_in) > 64'(MAXV));
                        cnt  <= '0;
                    end
                end
                CONVERT: begin
                    sreg <= shifted;
                    cnt  <= cnt + CW'(1);
                end
                ENCODE: begin
                    seg_frame <= frame_next;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_seg_frame.sv
// Bench for bin_to_seg_frame: directed vector table, multi-cycle corner
// sequences and randomized values against a decimal-arithmetic frame model.
module tb_bin_to_seg_frame;
    import seg_pkg::*;

    localparam int W = 32;
    localparam int LATENCY = 15;
    localparam logic [7:0] PAT [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                        8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [13:0]   bin_in;
    logic          busy, busy0;
    logic          done, done0;
    logic [W-1:0]  seg_frame, seg_frame0;
    seg_state_t    state, state0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp0_q[$];

    typedef struct {
        logic [13:0]  value;
        logic [W-1:0] exp_lzb;
        logic [W-1:0] exp_nolzb;
    } vec_t;
    vec_t vecs [8];

    bin_to_seg_frame #(.NUMCELLS(4), .BINW(14), .LZB(1)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .seg_frame(seg_frame), .state(state)
    );

    bin_to_seg_frame #(.NUMCELLS(4), .BINW(14), .LZB(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start), .bin_in(bin_in),
        .busy(busy0), .done(done0), .seg_frame(seg_frame0), .state(state0)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, blank cells beyond the digit count.
    function automatic logic [W-1:0] model_frame(input int unsigned v, input bit lzb);
        logic [W-1:0] f;
        int unsigned  p;
        int           nd;
        int unsigned  t;
        f = '0;
        if (v > 9999) return {4{8'h02}};
        nd = 1;
        t  = v / 10;
        while (t != 0) begin
            nd++;
            t = t / 10;
        end
        p = 1;
        for (int k = 0; k < 4; k++) begin
            if (lzb && k >= nd) f[8*k +: 8] = 8'h00;
            else                f[8*k +: 8] = PAT[(v / p) % 10];
            p = p * 10;
        end
        return f;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // driver: assumes we are 1ns after an edge; the next edge accepts
    task automatic launch(input logic [13:0] value);
        start  = 1'b1;
        bin_in = value;
        exp_q.push_back(model_frame(value, 1'b1));
        exp0_q.push_back(model_frame(value, 1'b0));
        step();
        start  = 1'b0;
        bin_in = 14'($urandom_range(0, 16383));
        check("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    // waits for done; optional busy-time start pulses at edges 3 and 7
    task automatic wait_result(input string name, input bit inject);
        int n;
        int dcount;
        logic [W-1:0] e, e0;
        n = 0;
        dcount = 0;
        for (int i = 1; i <= 40; i++) begin
            if (inject && (i == 3 || i == 7)) begin
                start  = 1'b1;
                bin_in = 14'd8888;
            end
            step();
            start = 1'b0;
            if (done) begin
                n = i;
                dcount++;
                break;
            end
        end
        if (dcount == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done at edge %0d", name, LATENCY);
        end else begin
            check({name, "_latency"}, n, LATENCY);
            check({name, "_busy_low"}, {31'b0, busy}, 32'd0);
            e  = exp_q.pop_front();
            e0 = exp0_q.pop_front();
            check({name, "_frame"}, seg_frame, e);
            check({name, "_frame_nolzb"}, seg_frame0, e0);
        end
    endtask

    initial begin
        vecs[0] = '{14'd5678,  32'hB6BEE0FE, 32'hB6BEE0FE};
        vecs[1] = '{14'd42,    32'h000066DA, 32'hFCFC66DA};
        vecs[2] = '{14'd0,     32'h000000FC, 32'hFCFCFCFC};
        vecs[3] = '{14'd10000, 32'h02020202, 32'h02020202};
        vecs[4] = '{14'd9999,  32'hF6F6F6F6, 32'hF6F6F6F6};
        vecs[5] = '{14'd1234,  32'h60DAF266, 32'h60DAF266};
        vecs[6] = '{14'd8888,  32'hFEFEFEFE, 32'hFEFEFEFE};
        vecs[7] = '{14'd16383, 32'h02020202, 32'h02020202};

        // reset held 3 cycles with start asserted
        reset_n = 1'b0;
        start   = 1'b1;
        bin_in  = 14'd1234;
        repeat (3) step();
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_frame", seg_frame, 32'h0);
        check("reset_state", {30'b0, state}, {30'b0, IDLE});
        reset_n = 1'b1;
        start   = 1'b0;
        step();
        check("idle_after_reset", {31'b0, busy}, 32'd0);

        // directed table
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].value);
            wait_result($sformatf("vec%0d", i), 1'b0);
            check($sformatf("vec%0d_tab", i), seg_frame, vecs[i].exp_lzb);
            check($sformatf("vec%0d_tab_nolzb", i), seg_frame0, vecs[i].exp_nolzb);
            step();
            check($sformatf("vec%0d_done_drop", i), {31'b0, done}, 32'd0);
            check($sformatf("vec%0d_hold", i), seg_frame, vecs[i].exp_lzb);
        end

        // start while busy is ignored, start in the done cycle is accepted
        launch(14'd1234);
        wait_result("busy_ignore", 1'b1);
        check("busy_ignore_tab", seg_frame, 32'h60DAF266);
        launch(14'd8888);
        wait_result("done_cycle_start", 1'b0);
        check("done_cycle_start_tab", seg_frame, 32'hFEFEFEFE);
        step();

        // reset at edge 6 aborts the conversion
        launch(14'd5678);
        for (int i = 1; i < 6; i++) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("abort_frame", seg_frame, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_state", {30'b0, state}, {30'b0, IDLE});
        begin
            int dn;
            dn = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (done) dn++;
            end
            check("abort_no_done", dn, 0);
        end
        void'(exp_q.pop_front());
        void'(exp0_q.pop_front());
        launch(14'd5678);
        wait_result("after_abort", 1'b0);
        step();

        // randomized values
        for (int i = 0; i < 40; i++) begin
            logic [13:0] v;
            case (i % 3)
                0:       v = 14'($urandom_range(0, 16383));
                1:       v = 14'($urandom_range(0, 999));
                default: v = 14'($urandom_range(0, 99));
            endcase
            launch(v);
            wait_result($sformatf("rand%0d_v%0d", i, v), 1'b0);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
